// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the fetch unit / load-store buffer and
// the byte-serial memory controller.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_en;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [DATA_WIDTH-1:0] if_data;

  logic                  lsb_en;
  logic                  lsb_rw;
  logic [1:0]            lsb_width;
  logic [ADDR_WIDTH-1:0] lsb_addr;
  logic [DATA_WIDTH-1:0] lsb_wdata;
  logic                  lsb_done;
  logic [DATA_WIDTH-1:0] lsb_rdata;

  // Requester side: the fetch unit and the load/store buffer.
  modport master (
    output if_en, if_addr, lsb_en, lsb_rw, lsb_width, lsb_addr, lsb_wdata,
    input  if_done, if_data, lsb_done, lsb_rdata
  );

  // Controller side.
  modport slave (
    input  if_en, if_addr, lsb_en, lsb_rw, lsb_width, lsb_addr, lsb_wdata,
    output if_done, if_data, lsb_done, lsb_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serves instruction fetches and load/store
// requests over an 8-bit RAM port, one byte per cycle, little-endian.
// Load/store requests win over fetches; reads can be flushed by roll_back,
// stores always commit.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  roll_back,
  input  logic                  io_buffer_full,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  mem_ctrl_if.slave             bus
);

  typedef enum logic [1:0] {IDLE, IF_RD, LSB_RD, LSB_WR} state_t;

  state_t                state;
  logic [2:0]            cnt;
  logic [2:0]            total;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rbuf;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [7:0]            dout_q;
  logic                  wr_q;
  logic                  if_done_q;
  logic                  lsb_done_q;
  logic [DATA_WIDTH-1:0] if_data_q;
  logic [DATA_WIDTH-1:0] lsb_rdata_q;
  logic [1:0]            rd_idx;
  logic [1:0]            wr_idx;
  logic                  is_io;
  logic                  io_stall;

  function automatic logic [2:0] byte_total(input logic [1:0] w);
    case (w)
      2'b00:   byte_total = 3'd1;
      2'b01:   byte_total = 3'd2;
      default: byte_total = 3'd4;
    endcase
  endfunction

  // Read data for byte k arrives two cycles after it was issued, so the
  // byte landing at this edge belongs to slot cnt-1.
  assign rd_idx   = cnt[1:0] - 2'd1;
  assign wr_idx   = cnt[1:0] + 2'd1;
  assign is_io    = (addr_q[17:16] == 2'b11);
  assign io_stall = (state == LSB_WR) && is_io && io_buffer_full;

  // Write strobe is suppressed while paused or while the UART buffer is full.
  assign mem_wr   = wr_q && rdy_in && !io_stall;
  assign mem_a    = a_q;
  assign mem_dout = dout_q;

  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.lsb_done  = lsb_done_q;
  assign bus.lsb_rdata = lsb_rdata_q;

  // Merge the incoming RAM byte into the partially assembled read word.
  always_comb begin
    rd_word = rbuf;
    rd_word[{rd_idx, 3'b000} +: 8] = mem_din;
  end

  // Transfer sequencer: arbitration, byte stepping, completion and abort.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      total       <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf        <= '0;
      a_q         <= '0;
      dout_q      <= 8'd0;
      wr_q        <= 1'b0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_data_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (!rdy_in) begin
      if (roll_back && (state == IF_RD || state == LSB_RD)) begin
        state <= IDLE;
        cnt   <= 3'd0;
        a_q   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if_done_q  <= 1'b0;
          lsb_done_q <= 1'b0;
          if (!roll_back && !if_done_q && !lsb_done_q) begin
            if (bus.lsb_en) begin
              addr_q  <= bus.lsb_addr;
              total   <= byte_total(bus.lsb_width);
              wdata_q <= bus.lsb_wdata;
              cnt     <= 3'd0;
              rbuf    <= '0;
              a_q     <= bus.lsb_addr;
              if (bus.lsb_rw) begin
                state  <= LSB_WR;
                wr_q   <= 1'b1;
                dout_q <= bus.lsb_wdata[7:0];
              end else begin
                state <= LSB_RD;
              end
            end else if (bus.if_en) begin
              addr_q <= bus.if_addr;
              total  <= 3'd4;
              cnt    <= 3'd0;
              rbuf   <= '0;
              a_q    <= bus.if_addr;
              state  <= IF_RD;
            end
          end
        end

        IF_RD, LSB_RD: begin
          if (roll_back) begin
            state <= IDLE;
            cnt   <= 3'd0;
            a_q   <= '0;
          end else begin
            if (cnt != 3'd0) rbuf <= rd_word;
            if (cnt == total) begin
              state <= IDLE;
              cnt   <= 3'd0;
              a_q   <= '0;
              if (state == IF_RD) begin
                if_data_q <= rd_word;
                if_done_q <= 1'b1;
              end else begin
                lsb_rdata_q <= rd_word;
                lsb_done_q  <= 1'b1;
              end
            end else begin
              cnt <= cnt + 3'd1;
              if ((cnt + 3'd1) < total)
                a_q <= addr_q + ADDR_WIDTH'(cnt + 3'd1);
              else
                a_q <= '0;
            end
          end
        end

        LSB_WR: begin
          if (!io_stall) begin
            if ((cnt + 3'd1) == total) begin
              state      <= IDLE;
              cnt        <= 3'd0;
              wr_q       <= 1'b0;
              a_q        <= '0;
              dout_q     <= 8'd0;
              lsb_done_q <= 1'b1;
            end else begin
              cnt    <= cnt + 3'd1;
              a_q    <= addr_q + ADDR_WIDTH'(cnt + 3'd1);
              dout_q <= wdata_q[{wr_idx, 3'b000} +: 8];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a one-cycle-latency byte RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        roll_back;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  mem_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .roll_back      (roll_back),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  ram [0:262143];
  logic [31:0] wr_a [$];
  logic [7:0]  wr_d [$];
  logic [31:0] seen [4];
  int          errors = 0;
  int          checks = 0;
  int          lat;
  int          hits;

  // RAM model: registered read, write on the strobe, every write logged.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) begin
      ram[mem_a[17:0]] <= mem_dout;
      wr_a.push_back(mem_a);
      wr_d.push_back(mem_dout);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit lsb, input bit rw, input logic [1:0] w,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (lsb) begin
      bus.lsb_en    = 1'b1;
      bus.lsb_rw    = rw;
      bus.lsb_width = w;
      bus.lsb_addr  = addr;
      bus.lsb_wdata = wdata;
    end else begin
      bus.if_en   = 1'b1;
      bus.if_addr = addr;
    end
  endtask

  // Returns edges from the accept edge to the visible done pulse (-1 on timeout),
  // releases the request and checks the pulse drops after one cycle.
  task automatic wait_done(input bit lsb, output int l);
    l = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (lsb ? bus.lsb_done : bus.if_done) begin
        l = i;
        break;
      end
    end
    if (lsb) bus.lsb_en = 1'b0;
    else     bus.if_en  = 1'b0;
    @(negedge clk);
    checkOutput(lsb ? "lsb_done_pulse" : "if_done_pulse",
                32'(lsb ? bus.lsb_done : bus.if_done), 32'd0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0; io_buffer_full = 1'b0;
    bus.if_en = 1'b0; bus.if_addr = '0;
    bus.lsb_en = 1'b0; bus.lsb_rw = 1'b0; bus.lsb_width = 2'b00;
    bus.lsb_addr = '0; bus.lsb_wdata = '0;
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram['h100] = 8'h13; ram['h101] = 8'h05; ram['h102] = 8'hA0; ram['h103] = 8'h00;
    ram['h104] = 8'h93; ram['h105] = 8'h08; ram['h106] = 8'h10; ram['h107] = 8'h00;
    ram['h20]  = 8'hF7;

    repeat (3) @(negedge clk);
    checkOutput("rst_mem_wr", 32'(mem_wr), 32'd0);
    checkOutput("rst_mem_a", mem_a, 32'd0);
    checkOutput("rst_mem_dout", 32'(mem_dout), 32'd0);
    checkOutput("rst_if_done", 32'(bus.if_done), 32'd0);
    checkOutput("rst_lsb_done", 32'(bus.lsb_done), 32'd0);
    checkOutput("rst_if_data", bus.if_data, 32'd0);
    checkOutput("rst_lsb_rdata", bus.lsb_rdata, 32'd0);
    rst_in = 1'b0;

    $display("[TB] fetch 0x100");
    applyStimulus(0, 0, 2'b00, 32'h100, 32'h0);
    fork
      wait_done(0, lat);
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          seen[k] = mem_a;
        end
      end
    join
    checkOutput("if_latency", lat, 32'd5);
    for (int k = 0; k < 4; k++) checkOutput("if_mem_a_step", seen[k], 32'h100 + k);
    checkOutput("if_data", bus.if_data, 32'h00A00513);
    checkOutput("idle_mem_a", mem_a, 32'd0);

    $display("[TB] word store 0xDEADBEEF to 0x40");
    wr_a.delete(); wr_d.delete();
    applyStimulus(1, 1, 2'b10, 32'h40, 32'hDEADBEEF);
    wait_done(1, lat);
    checkOutput("st_latency", lat, 32'd4);
    checkOutput("st_count", wr_a.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      checkOutput("st_addr", wr_a[k], 32'h40 + k);
      checkOutput("st_byte", 32'(wr_d[k]), (32'hDEADBEEF >> (8 * k)) & 32'hFF);
    end

    $display("[TB] word / byte / half loads");
    applyStimulus(1, 0, 2'b10, 32'h40, 32'h0);
    wait_done(1, lat);
    checkOutput("ldw_latency", lat, 32'd5);
    checkOutput("ldw_data", bus.lsb_rdata, 32'hDEADBEEF);
    checkOutput("if_data_hold", bus.if_data, 32'h00A00513);
    applyStimulus(1, 0, 2'b00, 32'h20, 32'h0);
    wait_done(1, lat);
    checkOutput("ldb_latency", lat, 32'd2);
    checkOutput("ldb_data", bus.lsb_rdata, 32'h000000F7);
    applyStimulus(1, 0, 2'b01, 32'h41, 32'h0);
    wait_done(1, lat);
    checkOutput("ldh_latency", lat, 32'd3);
    checkOutput("ldh_data", bus.lsb_rdata, 32'h0000ADBE);

    $display("[TB] IO store with buffer full");
    wr_a.delete(); wr_d.delete();
    io_buffer_full = 1'b1;
    applyStimulus(1, 1, 2'b00, 32'h30000, 32'h41);
    fork
      wait_done(1, lat);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checkOutput("io_wr_while_full", 32'(mem_wr), 32'd0);
        end
        @(negedge clk);
        io_buffer_full = 1'b0;
      end
    join
    checkOutput("io_latency", lat, 32'd4);
    checkOutput("io_count", wr_a.size(), 32'd1);
    checkOutput("io_addr", wr_a[0], 32'h30000);
    checkOutput("io_byte", 32'(wr_d[0]), 32'h41);

    $display("[TB] arbitration");
    applyStimulus(0, 0, 2'b00, 32'h104, 32'h0);
    applyStimulus(1, 0, 2'b00, 32'h20, 32'h0);
    wait_done(1, lat);
    checkOutput("arb_lsb_latency", lat, 32'd2);
    checkOutput("arb_lsb_data", bus.lsb_rdata, 32'h000000F7);
    checkOutput("arb_if_not_yet", mem_a, 32'd0);
    wait_done(0, lat);
    checkOutput("arb_if_latency", lat, 32'd5);
    checkOutput("arb_if_data", bus.if_data, 32'h00100893);

    $display("[TB] roll_back during fetch");
    applyStimulus(0, 0, 2'b00, 32'h100, 32'h0);
    repeat (2) @(negedge clk);
    roll_back = 1'b1;
    @(negedge clk);
    roll_back = 1'b0;
    bus.if_en = 1'b0;
    checkOutput("rb_mem_a", mem_a, 32'd0);
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.if_done) hits++;
    end
    checkOutput("rb_no_if_done", hits, 32'd0);
    checkOutput("rb_if_data", bus.if_data, 32'h00100893);

    $display("[TB] roll_back during store");
    wr_a.delete(); wr_d.delete();
    applyStimulus(1, 1, 2'b10, 32'h50, 32'h12345678);
    fork
      wait_done(1, lat);
      begin
        @(negedge clk);
        roll_back = 1'b1;
      end
    join
    roll_back = 1'b0;
    checkOutput("rbst_latency", lat, 32'd4);
    checkOutput("rbst_count", wr_a.size(), 32'd4);
    checkOutput("rbst_ram", {ram['h53], ram['h52], ram['h51], ram['h50]}, 32'h12345678);

    $display("[TB] rdy_in pause during store");
    wr_a.delete(); wr_d.delete();
    applyStimulus(1, 1, 2'b10, 32'h60, 32'hCAFEF00D);
    fork
      wait_done(1, lat);
      begin
        repeat (2) @(negedge clk);
        rdy_in = 1'b0;
        #1 checkOutput("rdy_mem_wr", 32'(mem_wr), 32'd0);
        repeat (3) @(negedge clk);
        rdy_in = 1'b1;
      end
    join
    checkOutput("rdy_latency", lat, 32'd7);
    checkOutput("rdy_count", wr_a.size(), 32'd4);
    checkOutput("rdy_ram", {ram['h63], ram['h62], ram['h61], ram['h60]}, 32'hCAFEF00D);

    $display("[TB] reset mid-transfer");
    applyStimulus(1, 0, 2'b10, 32'h40, 32'h0);
    repeat (2) @(negedge clk);
    rst_in = 1'b1;
    bus.lsb_en = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_rdata", bus.lsb_rdata, 32'd0);
    checkOutput("mid_rst_mem_a", mem_a, 32'd0);
    rst_in = 1'b0;
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.lsb_done) hits++;
    end
    checkOutput("mid_rst_no_done", hits, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, byte address width.
REQ-002 Parameter: DATA_WIDTH, 32, request/response data width.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-high.
REQ-005 rdy_in  input  1  ready; when low, controller pauses.
REQ-006 roll_back  input  1  misprediction flush.
REQ-007 io_buffer_full  input  1  UART output buffer full.
REQ-008 mem_din  input  8  RAM read byte.
REQ-009 mem_dout  output  8  RAM write byte.
REQ-010 mem_a  output  32  RAM byte address.
REQ-011 mem_wr  output  1  RAM write strobe, 1 = write.
REQ-012 if_en  input  1  fetch request, level, held until if_done.
REQ-013 if_addr  input  32  fetch word address.
REQ-014 if_done  output  1  one-cycle fetch completion pulse.
REQ-015 if_data  output  32  fetched instruction word.
REQ-016 lsb_en  input  1  load/store request, level, held until lsb_done.
REQ-017 lsb_rw  input  1  1 = store, 0 = load.
REQ-018 lsb_width  input  2  00 byte, 01 half, 10 word.
REQ-019 lsb_addr  input  32  access address.
REQ-020 lsb_wdata  input  32  store data; low bytes used.
REQ-021 lsb_done  output  1  one-cycle load/store completion pulse.
REQ-022 lsb_rdata  output  32  load data, zero-extended raw bytes.

Function
REQ-023 States: IDLE, IF_RD, LSB_RD, LSB_WR. Byte counter and byte total n: 1/2/4 per lsb_width; fetch n = 4.
REQ-024 IDLE with lsb_en high: latch lsb_addr, lsb_width, lsb_rw, lsb_wdata; go to LSB_WR or LSB_RD. LSB has priority over IF.
REQ-025 IDLE with only if_en high: latch if_addr; go to IF_RD.
REQ-026 Request inputs are ignored outside IDLE and in the cycle a done pulse is high.
REQ-027 Byte k (k = 0..n-1) uses address latched_addr + k; bytes are little-endian, byte k maps to data bits [8k+7:8k].
REQ-028 Read: mem_a = addr+k during cycle k+1 after the accept edge; mem_din carries byte k during cycle k+2; done asserts after accept edge + n+1 (word: 5 edges).
REQ-029 Write: mem_wr = 1, mem_a = addr+k, mem_dout = byte k during cycle k+1; done asserts after accept edge + n (word: 4 edges).
REQ-030 On completion: state returns to IDLE; the matching done pulses high exactly one cycle.
REQ-031 lsb_rdata and if_data hold their last value until the next read of the same port completes.
REQ-032 Unused upper bytes of lsb_rdata are 0.
REQ-033 IO region: address bits [17:16] = 2'b11.
REQ-034 In LSB_WR to the IO region, if io_buffer_full is high, mem_wr = 0 and the byte counter does not advance. Progress resumes in the first cycle it is low.
REQ-035 roll_back in IF_RD or LSB_RD: abort to IDLE at that edge; no done pulse; mem_wr = 0.
REQ-036 roll_back in LSB_WR is ignored: stores are committed and complete normally.
REQ-037 roll_back in IDLE: no request is accepted that cycle.
REQ-038 rdy_in low:
- no state, counter or output register changes;
- mem_wr driven 0;
- roll_back still applies per REQ-035.
REQ-039 When not writing, mem_wr = 0. In IDLE, mem_a = 0 and mem_dout = 0.
REQ-040 Simultaneous if_en and lsb_en in IDLE: LSB served first; IF accepted in the first IDLE cycle after lsb_done.

Reset
REQ-041 rst_in high asynchronously forces:
- state IDLE, counter 0;
- mem_wr, mem_a, mem_dout = 0;
- if_done, lsb_done = 0; if_data, lsb_rdata = 0.
REQ-042 Reset mid-transfer discards the transfer: no done pulse after release.
REQ-043 The first request is accepted on the first rising edge with rst_in low and rdy_in high.

Verification
REQ-044 Fetch: RAM[0x100..0x103] = 13 05 A0 00, if_en with addr 0x100 -> mem_a steps 0x100..0x103; if_done high 5 edges after accept; if_data = 0x00A00513.
REQ-045 Byte load: RAM[0x20] = 0xF7, lsb_width = 00, lsb_rw = 0 -> lsb_done after 2 edges; lsb_rdata = 0x000000F7.
REQ-046 Word store: 0xDEADBEEF to 0x40 -> mem_wr high 4 cycles, bytes EF BE AD DE at 0x40..0x43; lsb_done after 4 edges.
REQ-047 IO store: 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> no mem_wr while full; one write of 0x41 to 0x30000 after release, then lsb_done.
REQ-048 Abort and arbitration:
- if_en and lsb_en asserted together -> LSB served first;
- roll_back asserted 2 cycles into the IF read -> no if_done, return to IDLE;
- roll_back during a store -> the store completes.
